// File: rtl/mcu_el2_pkg.sv
// mcu_el2_pkg
// Shared types for the EL2 PMP path:
//   mcu_param_t / mcu_pt      core build parameters (PMP entry count)
//   mcu_el2_pmp_mode_t        pmpcfg address-matching mode
//   mcu_el2_pmp_cfg_pkt_t     one pmpcfg byte
//   mcu_el2_pmp_region_t      decoded byte-granular [base, limit) region
//   mcu_el2_pmp_walk_state_e  region walker FSM state
package mcu_el2_pkg;

  typedef struct packed {
    logic [6:0] PMP_ENTRIES;
  } mcu_param_t;

  localparam mcu_param_t mcu_pt = '{PMP_ENTRIES: 7'd16};

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } mcu_el2_pmp_mode_t;

  typedef struct packed {
    logic              lock;
    logic [1:0]        reserved;
    mcu_el2_pmp_mode_t mode;
    logic              execute;
    logic              write;
    logic              read;
  } mcu_el2_pmp_cfg_pkt_t;

  // limit is exclusive and one bit wider than base so that a region
  // reaching the top of the address space can end at 2^32.
  typedef struct packed {
    logic [31:0] base;
    logic [32:0] limit;
    logic        valid;
    logic        r;
    logic        w;
    logic        x;
    logic        lock;
  } mcu_el2_pmp_region_t;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } mcu_el2_pmp_walk_state_e;

endpackage

// File: rtl/mcu_el2_pmp_napot_decode.sv
// mcu_el2_pmp_napot_decode
// Combinational NAPOT decode of one pmpaddr value.
// Ports:
//   pmpaddr [29:0]  in   pmpaddr bits 29:0
//   base    [31:0]  out  naturally aligned region base
//   limit   [32:0]  out  exclusive region end, saturated at 2^32
module mcu_el2_pmp_napot_decode (
  input  logic [29:0] pmpaddr,
  output logic [31:0] base,
  output logic [32:0] limit
);

  logic [32:0] ones;
  logic [32:0] mask;
  logic [33:0] sum;

  // Appending three ones makes the trailing-ones run exactly t+3 bits long,
  // so isolating that run yields size-1 without counting anything.
  assign ones  = {pmpaddr, 3'b111};
  assign mask  = ones & ~(ones + 33'd1);
  assign base  = {pmpaddr, 2'b00} & ~mask[31:0];
  assign sum   = {2'b00, base} + {1'b0, mask} + 34'd1;

  // Only the all-ones pattern (size 2^33) can exceed the address space.
  assign limit = (sum > 34'h1_0000_0000) ? 33'h1_0000_0000 : sum[32:0];

endmodule

// File: rtl/mcu_el2_pmp_region_walker.sv
// mcu_el2_pmp_region_walker
// Walks the PMP entries one per cycle after every PMP CSR write and
// registers each pmpcfg/pmpaddr pair as a decoded [base, limit) region.
// Optional feature macro: MCU_PMP_WALK_ERR_EN (sticky malformed-TOR flag).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pmp_cfg_chg         pulse on any committed PMP CSR write
//   pmp_pmpcfg          current entry configurations
//   pmp_pmpaddr         current entry addresses (bits 31:30 are zero)
//   pmp_region          registered decoded region table
//   pmp_regions_ready   table coherent with the CSRs
//   pmp_walk_busy       walk in progress
//   pmp_walk_err        sticky malformed-entry flag      (MCU_PMP_WALK_ERR_EN)
//   pmp_walk_err_idx    index of first malformed entry   (MCU_PMP_WALK_ERR_EN)
//   pmp_walk_err_clr    clears flag and index            (MCU_PMP_WALK_ERR_EN)
module mcu_el2_pmp_region_walker
  import mcu_el2_pkg::*;
#(
  parameter int PMP_ENTRIES = int'(mcu_pt.PMP_ENTRIES),
  // Kept at least 1 bit wide so the index ports stay legal with 0 entries.
  parameter int IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmp_cfg_chg,
  input  mcu_el2_pmp_cfg_pkt_t pmp_pmpcfg  [PMP_ENTRIES],
  input  logic [31:0]          pmp_pmpaddr [PMP_ENTRIES],
  output mcu_el2_pmp_region_t  pmp_region  [PMP_ENTRIES],
  output logic                 pmp_regions_ready,
  output logic                 pmp_walk_busy
`ifdef MCU_PMP_WALK_ERR_EN
  ,
  output logic                 pmp_walk_err,
  output logic [IDX_W-1:0]     pmp_walk_err_idx,
  input  logic                 pmp_walk_err_clr
`endif
);

  if (PMP_ENTRIES == 0) begin : g_none
    assign pmp_regions_ready = 1'b1;
    assign pmp_walk_busy     = 1'b0;
`ifdef MCU_PMP_WALK_ERR_EN
    assign pmp_walk_err      = 1'b0;
    assign pmp_walk_err_idx  = '0;
`endif
  end else begin : g_walk

    mcu_el2_pmp_walk_state_e state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    last;
    mcu_el2_pmp_cfg_pkt_t    cur_cfg;
    logic [31:0]             cur_addr, prev_addr;
    logic [31:0]             a, tor_base;
    logic [31:0]             napot_base;
    logic [32:0]             napot_limit;
    mcu_el2_pmp_region_t     dec;
    mcu_el2_pmp_region_t     region_q [PMP_ENTRIES];
    logic                    unused_bits;

    assign last      = (idx_q == IDX_W'(PMP_ENTRIES - 1));
    assign cur_cfg   = pmp_pmpcfg[idx_q];
    assign cur_addr  = pmp_pmpaddr[idx_q];
    assign prev_addr = (idx_q == '0) ? 32'd0 : pmp_pmpaddr[idx_q - IDX_W'(1)];
    assign a         = {cur_addr[29:0], 2'b00};
    assign tor_base  = {prev_addr[29:0], 2'b00};

    mcu_el2_pmp_napot_decode u_napot (
      .pmpaddr (cur_addr[29:0]),
      .base    (napot_base),
      .limit   (napot_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
      end
    end

    // A CSR write during a walk restarts it from entry 0 so the table
    // always ends up matching the most recent CSR values.
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
        IDLE: begin
          if (pmp_cfg_chg) begin
            state_d = WALK;
            idx_d   = '0;
          end
        end
        WALK: begin
          if (pmp_cfg_chg) begin
            idx_d = '0;
          end else if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    always_comb begin
      dec = '0;
      unique case (cur_cfg.mode)
        TOR: begin
          dec.base  = tor_base;
          dec.limit = {1'b0, a};
          dec.valid = (tor_base < a);
        end
        NA4: begin
          dec.base  = a;
          dec.limit = {1'b0, a} + 33'd4;
          dec.valid = 1'b1;
        end
        NAPOT: begin
          dec.base  = napot_base;
          dec.limit = napot_limit;
          dec.valid = 1'b1;
        end
        default: ;
      endcase
      dec.r    = cur_cfg.read;
      dec.w    = cur_cfg.write;
      dec.x    = cur_cfg.execute;
      dec.lock = cur_cfg.lock;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          region_q[i] <= '0;
        end
      end else if (state_q == WALK) begin
        region_q[idx_q] <= dec;
      end
    end

    assign pmp_region        = region_q;
    assign pmp_walk_busy     = (state_q == WALK);
    assign pmp_regions_ready = (state_q == IDLE) & ~pmp_cfg_chg;

    // Address bits 31:30 and the reserved cfg bits carry no information.
    always_comb begin
      unused_bits = 1'b0;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        unused_bits = unused_bits ^ (^{pmp_pmpaddr[i][31:30], pmp_pmpcfg[i].reserved});
      end
    end

`ifdef MCU_PMP_WALK_ERR_EN
    logic             err_q;
    logic [IDX_W-1:0] err_idx_q;
    logic             tor_bad;

    assign tor_bad = (state_q == WALK) && (cur_cfg.mode == TOR) && (tor_base > a);

    // Only the first malformed entry is recorded; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        err_q     <= 1'b0;
        err_idx_q <= '0;
      end else if (tor_bad && !err_q) begin
        err_q     <= 1'b1;
        err_idx_q <= idx_q;
      end else if (pmp_walk_err_clr) begin
        err_q     <= 1'b0;
        err_idx_q <= '0;
      end
    end

    assign pmp_walk_err     = err_q;
    assign pmp_walk_err_idx = err_idx_q;
`endif

  end

endmodule

// File: doc/mcu_el2_pmp_region_walker.md
# mcu_el2_pmp_region_walker

Sequential decoder between the PMP CSR block and the PMP address checkers. On every PMP CSR write it walks the PMP entries, one entry per cycle, and converts each `pmpcfg`/`pmpaddr` pair into a byte-granular `[base, limit)` region with its permissions. The registered region table feeds the fetch and load/store checkers. A ready flag marks when the table is coherent with the CSRs; while it is low, consumers stall PMP-checked accesses.

## Interface
- `PMP_ENTRIES`, default `mcu_pt.PMP_ENTRIES` (16): number of PMP entries; legal values are 0, 16 and 64.
- `IDX_W`, default `$clog2(PMP_ENTRIES)`: width of the entry index.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pmp_cfg_chg`  in  1  single-cycle pulse on any committed PMP CSR write, from the PMP CSR write enable.
- `pmp_pmpcfg`  in  `mcu_el2_pmp_cfg_pkt_t [PMP_ENTRIES]`  current entry configurations.
- `pmp_pmpaddr`  in  `32 x PMP_ENTRIES`  current entry addresses; bits 31:30 are always 0.
- `pmp_region`  out  `mcu_el2_pmp_region_t [PMP_ENTRIES]`  decoded table with fields `base[31:0]`, `limit[32:0]` (exclusive), `valid`, `r`, `w`, `x`, `lock`.
- `pmp_regions_ready`  out  1  table is coherent with the CSRs.
- `pmp_walk_busy`  out  1  walk in progress.
- `pmp_walk_err`  out  1  sticky malformed-entry flag (only with `MCU_PMP_WALK_ERR_EN`).
- `pmp_walk_err_idx`  out  `IDX_W`  index of the first malformed entry (only with `MCU_PMP_WALK_ERR_EN`).
- `pmp_walk_err_clr`  in  1  clears the error flag and index (only with `MCU_PMP_WALK_ERR_EN`).

## Operation
- FSM states are `IDLE` and `WALK`. Entry counter `idx_q`.
- `IDLE` with `pmp_cfg_chg`: go to `WALK` and set `idx_q`=0.
- `WALK`: decode entry `idx_q` and register the result into `pmp_region[idx_q]`, then increment `idx_q`.
  - After the last entry (`idx_q`==`PMP_ENTRIES`-1), return to `IDLE`.
- `pmp_cfg_chg` while in `WALK`: restart at `idx_q`=0 on the next cycle. Entries already written stay as they are until they are rewritten.
- Decode of entry `i`, with `a = {pmpaddr[29:0], 2'b00}`:
  - **OFF**: `valid`=0; `base` and `limit` are don't-care but are written as 0.
  - **TOR**: `base` = (i==0) ? 0 : `{pmpaddr[i-1][29:0], 2'b00}`; `limit` = zero-extended `a`; `valid` = (`base` < `limit`).
  - **NA4**: `base` = `a`; `limit` = `a`+4; `valid`=1.
  - **NAPOT**: `t` = number of trailing ones in `pmpaddr[29:0]` (0..30). Region size is 2^(t+3) bytes. `base` = `a` with bits [t+2:0] cleared. `limit` = `base`+size, saturated at 2^32 (33-bit arithmetic). `valid`=1.
- Permission and lock bits `r`, `w`, `x` and `lock` are copied unchanged from `pmpcfg`.
- `pmp_regions_ready` = (state==`IDLE`) & ~`pmp_cfg_chg`. It is combinational, so consumers see it drop in the same cycle as the CSR write.
- `pmp_walk_busy` = (state==`WALK`).

## Timing
- Reset values:
  - state=`IDLE`, `idx_q`=0.
  - All `pmp_region` entries are 0 (`valid`=0).
  - `pmp_regions_ready`=1 and `pmp_walk_busy`=0.
  - `pmp_walk_err`=0 and `pmp_walk_err_idx`=0.
  - These values are consistent with the all-zero CSR reset state.
- `pmp_cfg_chg` in cycle N:
  - Entry k is updated at the clock edge ending cycle N+1+k.
  - `pmp_walk_busy` is high in cycles N+1 .. N+`PMP_ENTRIES`.
  - `pmp_regions_ready` is low from cycle N through N+`PMP_ENTRIES` and returns high in cycle N+1+`PMP_ENTRIES`.
- Back-to-back pulses: each pulse restarts the walk. Ready returns `PMP_ENTRIES`+1 cycles after the last pulse.
- `rst` asserted mid-walk: the FSM and table clear immediately.
- `PMP_ENTRIES`=0: the FSM is tied to `IDLE` and `pmp_regions_ready`=1 constantly.

## Configuration
- `MCU_PMP_WALK_ERR_EN` defined:
  - During the walk, a TOR entry with `base` > `limit` sets `pmp_walk_err`, provided the flag is clear, and latches the entry index into `pmp_walk_err_idx`.
  - `pmp_walk_err_clr` clears both. If a set and a clear occur in the same cycle, the set wins.
- `MCU_PMP_WALK_ERR_EN` undefined: the error ports are absent and no error logic is generated.

## Structure
- The `mcu_el2_pmp_region_t` typedef and the walker state enum `mcu_el2_pmp_walk_state_e` are added to `mcu_el2_pkg`.
- One combinational sub-module, `mcu_el2_pmp_napot_decode`, takes `pmpaddr[29:0]` and produces the NAPOT `base` and saturated `limit`.

## Test plan
- **Reset, then idle:** all regions have `valid`=0; `ready`=1; `busy`=0.
- **NAPOT decode:** entry 0 with `pmpaddr`=0x0000_03FF in NAPOT mode, then a pulse. After `PMP_ENTRIES`+1 cycles, `base`=0x0, `limit`=0x2000, `valid`=1.
- **TOR decode:** entry 1 in TOR with `pmpaddr1`=0x400 and `pmpaddr0`=0x100 → `base`=0x400, `limit`=0x1000. Then swap the two addresses → `valid`=0; with `MCU_PMP_WALK_ERR_EN`, also `err`=1 and `err_idx`=1.
- **Full NAPOT:** `pmpaddr`=0x3FFF_FFFF in NAPOT → `base`=0, `limit`=0x1_0000_0000 (saturated).
- **Restart mid-walk:** pulse, then a second pulse 5 cycles later. `ready` stays low until 17 cycles after the second pulse (16 entries); the final table matches the latest CSRs.
- **Reset mid-walk:** assert `rst` in cycle 3 of a walk → table cleared, `ready`=1 the following cycle.
